fifo_wr_skid: RTL and testbench
===============================

FIFO_WR_SKID -- requirements
Module: fifo_wr_skid

Interface
REQ-001 Parameter DW, default 32, data width of the upstream stream and the FIFO write port.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 nreset  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  DW  upstream write data.
REQ-005 in_valid  input  1  upstream data valid.
REQ-006 in_ready  output  1  block can accept in_data this cycle; driven only from registers (and nreset), no combinational path from in_valid or fifo_full.
REQ-007 fifo_din  output  DW  data to the FIFO write port; equals the main register.
REQ-008 fifo_wr_en  output  1  FIFO write strobe.
REQ-009 fifo_full  input  1  FIFO full flag; a write issued while fifo_full=1 is lost in the FIFO, so this block never issues one.
REQ-010 level  output  2  number of words held in this block (0, 1 or 2).

Function
REQ-011 Internal state: main register (main_data, main_valid) and skid register (skid_data, skid_valid).
REQ-012 accept = in_valid && in_ready; a word is transferred upstream only on a cycle with accept=1.
REQ-013 in_ready = nreset && !skid_valid.
REQ-014 fifo_wr_en = main_valid && !fifo_full (combinational from fifo_full); fifo_din = main_data.
REQ-015 Main slot free this cycle: main_free = !main_valid || fifo_wr_en.
REQ-016 If main_free and skid_valid: main_data <= skid_data, main_valid <= 1, skid_valid <= 0 (accept is 0 on this cycle per REQ-013).
REQ-017 If main_free, !skid_valid and accept: main_data <= in_data, main_valid <= 1.
REQ-018 If main_free, !skid_valid and !accept: main_valid <= 0; main_data holds.
REQ-019 If !main_free and accept: skid_data <= in_data, skid_valid <= 1; main holds.
REQ-020 If !main_free and !accept: all state holds.
REQ-021 Latency: a word accepted in cycle N appears on fifo_din with main_valid=1 in cycle N+1; fifo_wr_en asserts in N+1 if fifo_full=0.
REQ-022 Throughput: one word per cycle sustained while fifo_full=0 and in_valid=1; in_ready stays 1.
REQ-023 Word order into the FIFO equals upstream accept order; no word is duplicated or dropped.
REQ-024 When fifo_full rises with main_valid=1, at most one further word is accepted (into skid), then in_ready=0 next cycle.
REQ-025 When fifo_full falls with both slots valid: main written that cycle, skid moves to main, in_ready=1 the following cycle.
REQ-026 level = main_valid + skid_valid; skid_valid=1 implies main_valid=1 (level never reports skid without main).
REQ-027 in_valid is allowed to drop without a transfer; in_data is ignored when accept=0.

Reset
REQ-028 While nreset=0 at a rising edge: main_valid, skid_valid <= 0; main_data, skid_data <= 0.
REQ-029 While nreset=0: in_ready=0, fifo_wr_en=0; after the first edge with nreset=0, fifo_din=0 and level=0.
REQ-030 Reset mid-operation discards both held words; no write is issued on the cycle nreset=0; first cycle after release in_ready=1.

Verification
REQ-031 Stream 0x1..0x8 on consecutive cycles, fifo_full=0 -> fifo_wr_en high cycles 2..9 with fifo_din 0x1..0x8, in_ready constant 1, level 1 throughout.
REQ-032 Send 0xA then 0xB; fifo_full=1 from the cycle 0xA sits in main -> 0xB captured in skid, level=2, in_ready=0, fifo_wr_en=0; release fifo_full -> writes 0xA then 0xB on consecutive cycles, in_ready=1 one cycle after 0xA write.
REQ-033 Random in_valid (50%) and random fifo_full (30%), 10000 words -> scoreboard shows exact in-order match, fifo_wr_en never high with fifo_full=1, level never 3.
REQ-034 Both slots valid, assert nreset=0 one cycle -> level=0, fifo_wr_en=0, no write of held words; next word after release written with 1-cycle latency.
REQ-035 fifo_full toggling every cycle with in_valid=1 continuously -> no loss or duplication, in_ready never depends combinationally on fifo_full (check glitch-free vs. registered state).

Source files
------------

// File: rtl/fifo_wr_skid.sv
// Two-entry skid buffer between an upstream valid/ready stream and a FIFO write port.
// in_ready is derived only from registered state so fifo_full never reaches it combinationally.
module fifo_wr_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wr_en,
  input  logic          fifo_full,
  output logic [1:0]    level
);

  logic [DW-1:0] main_data;
  logic          main_valid;
  logic [DW-1:0] skid_data;
  logic          skid_valid;
  logic          accept;
  logic          main_free;

  assign in_ready   = nreset && !skid_valid;
  assign accept     = in_valid && in_ready;
  assign fifo_wr_en = nreset && main_valid && !fifo_full;
  assign fifo_din   = main_data;
  assign main_free  = !main_valid || fifo_wr_en;
  assign level      = {1'b0, main_valid} + {1'b0, skid_valid};

  // A full skid slot forces accept low, so the skid-to-main move never races a new word.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_skid.sv
// Bench for fifo_wr_skid: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_wr_skid;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic [1:0]  level;

  int tests = 0;
  int fails = 0;

  logic [31:0] held[$];
  logic [31:0] last_din = '0;
  int          accepted = 0;
  int          written = 0;

  always #5 clk = ~clk;

  fifo_wr_skid #(.DW(32)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .level      (level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: advance the model across the edge, apply new inputs, compare outputs.
  task automatic step(input logic rn, input logic iv, input logic [31:0] d, input logic ff);
    logic exp_rdy;
    logic exp_wr;
    logic rdy_before;
    @(posedge clk);
    if (!nreset) begin
      held.delete();
      last_din = '0;
    end else begin
      bit wr;
      bit acc;
      wr  = (held.size() > 0) && !fifo_full;
      acc = in_valid && (held.size() < 2);
      if (wr) begin
        void'(held.pop_front());
        written++;
      end
      if (acc) begin
        held.push_back(in_data);
        accepted++;
      end
      if (held.size() > 0) last_din = held[0];
    end
    #1;
    nreset = rn; in_valid = iv; in_data = d; fifo_full = ff;
    #2;
    exp_rdy = nreset && (held.size() < 2);
    exp_wr  = nreset && (held.size() > 0) && !fifo_full;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
    check("fifo_din", 64'(fifo_din), 64'(last_din));
    check("level", 64'(level), 64'(held.size()));
    // Wiggle fifo_full and in_valid mid-cycle: in_ready must not move.
    rdy_before = in_ready;
    fifo_full = ~ff; in_valid = ~iv;
    #1;
    check("in_ready_glitch", 64'(in_ready), 64'(rdy_before));
    check("wr_en_vs_full", 64'(fifo_wr_en), 64'(nreset && (held.size() > 0) && ff));
    fifo_full = ff; in_valid = iv;
    #1;
  endtask

  initial begin
    int cyc;
    // Reset
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hdead, 1'b0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_din", 64'(fifo_din), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);

    // Stream 1..8, fifo never full
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i < 8, 32'(i + 1), 1'b0);
      if (i == 0) check("s_ready0", 64'(in_ready), 64'd1);
      if (i >= 1 && i <= 8) begin
        check("s_wr_en", 64'(fifo_wr_en), 64'd1);
        check("s_din", 64'(fifo_din), 64'(i));
        check("s_level", 64'(level), 64'd1);
        check("s_ready", 64'(in_ready), 64'd1);
      end
      if (i == 9) check("s_drained", 64'(level), 64'd0);
    end

    // 0xA then 0xB with fifo_full while 0xA sits in main
    step(1'b1, 1'b1, 32'hA, 1'b0);
    step(1'b1, 1'b1, 32'hB, 1'b1);
    check("k_wr_en_full", 64'(fifo_wr_en), 64'd0);
    check("k_ready_1", 64'(in_ready), 64'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("k_level2", 64'(level), 64'd2);
    check("k_ready_0", 64'(in_ready), 64'd0);
    check("k_din_A_held", 64'(fifo_din), 64'hA);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("k_wr_A", 64'(fifo_wr_en), 64'd1);
    check("k_din_A", 64'(fifo_din), 64'hA);
    check("k_ready_still0", 64'(in_ready), 64'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("k_wr_B", 64'(fifo_wr_en), 64'd1);
    check("k_din_B", 64'(fifo_din), 64'hB);
    check("k_ready_back", 64'(in_ready), 64'd1);
    check("k_level1", 64'(level), 64'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("k_level0", 64'(level), 64'd0);

    // Reset with both slots holding words
    step(1'b1, 1'b1, 32'h11, 1'b1);
    step(1'b1, 1'b1, 32'h22, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("r_level2", 64'(level), 64'd2);
    check("r_no_write", 64'(fifo_wr_en), 64'd0);
    check("r_ready0", 64'(in_ready), 64'd0);
    step(1'b1, 1'b1, 32'h33, 1'b0);
    check("r_level0", 64'(level), 64'd0);
    check("r_din0", 64'(fifo_din), 64'd0);
    check("r_ready1", 64'(in_ready), 64'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("r_wr_33", 64'(fifo_wr_en), 64'd1);
    check("r_din_33", 64'(fifo_din), 64'h33);
    step(1'b1, 1'b0, 32'h0, 1'b0);

    // fifo_full toggling every cycle, in_valid held high
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 32'h1000 + 32'(i), i[0]);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t_drained", 64'(level), 64'd0);

    // Random traffic until 10000 words accepted, bounded by a cycle budget
    accepted = 0;
    written = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      step(1'b1, ($urandom_range(1) == 1), $urandom, ($urandom_range(9) < 3));
      cyc++;
    end
    check("rand_budget", 64'(accepted >= 10000), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("rand_all_written", 64'(written), 64'(accepted));
    check("rand_level0", 64'(level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
